clk_divider: RTL and testbench

- Power-of-two clock divider driven by a single input clock.
- A free-running CLK_DIVIDER_IN_BITS-wide counter increments on every clk_in rising edge.
- clk_out is the counter MSB: 50% duty, period 2^CLK_DIVIDER_IN_BITS input cycles.
- Used as a slow-clock / strobe source for low-rate logic and LED/demo logic; downstream logic should treat clk_out as a generated clock or sample it synchronously.

---
 rtl/clk_divider.sv | 59 +++++
 tb/tb_clk_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - power-of-two clock divider; optional wrap tick behind CLK_DIVIDER_TICK_EN
module clk_divider #(
  parameter int CLK_DIVIDER_IN_BITS = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_n,
  input  logic                           en,
`ifdef CLK_DIVIDER_TICK_EN
  output logic                           tick,
`endif
  output logic                           clk_out,
  output logic [CLK_DIVIDER_IN_BITS-1:0] count
);

  localparam logic [CLK_DIVIDER_IN_BITS-1:0] CountMax = '1;

  logic [CLK_DIVIDER_IN_BITS-1:0] count_q;
  logic [CLK_DIVIDER_IN_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + CLK_DIVIDER_IN_BITS'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The MSB flop is the divided clock itself, so clk_out carries no decode glitches.
  assign clk_out = count_q[CLK_DIVIDER_IN_BITS-1];
  assign count   = count_q;

`ifdef CLK_DIVIDER_TICK_EN
  logic tick_q;
  logic tick_d;

  // Registered one-cycle pulse that lines up with the wrap to zero.
  always_comb begin
    tick_d = en && (count_q == CountMax);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - randomized self-checking bench for clk_divider at N=1,2,3,4,8
module tb_clk_divider;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;

  always #10 clk_in = ~clk_in;

  logic       o1, o2, o3, o4, o8;
  logic [0:0] c1;
  logic [1:0] c2;
  logic [2:0] c3;
  logic [3:0] c4;
  logic [7:0] c8;
`ifdef CLK_DIVIDER_TICK_EN
  logic t1, t2, t3, t4, t8;
`endif

  clk_divider #(.CLK_DIVIDER_IN_BITS(1)) u_n1 (.clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
    .tick(t1),
`endif
    .clk_out(o1), .count(c1));
  clk_divider #(.CLK_DIVIDER_IN_BITS(2)) u_n2 (.clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
    .tick(t2),
`endif
    .clk_out(o2), .count(c2));
  clk_divider #(.CLK_DIVIDER_IN_BITS(3)) u_n3 (.clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
    .tick(t3),
`endif
    .clk_out(o3), .count(c3));
  clk_divider #(.CLK_DIVIDER_IN_BITS(4)) u_n4 (.clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
    .tick(t4),
`endif
    .clk_out(o4), .count(c4));
  clk_divider #(.CLK_DIVIDER_IN_BITS(8)) u_n8 (.clk_in(clk_in), .rst_n(rst_n), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
    .tick(t8),
`endif
    .clk_out(o8), .count(c8));

  int checks = 0;
  int errors = 0;

  // Reference: number of enabled edges since reset, and whether the last edge was enabled.
  int unsigned n_en    = 0;
  bit          last_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return n_en % (32'd1 << n);
  endfunction

  function automatic logic [31:0] exp_out(input int n);
    return (exp_cnt(n) >= (32'd1 << (n - 1))) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_tick(input int n);
    return (last_en && n_en != 0 && exp_cnt(n) == 0) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_all();
    check_eq("n1_count", 32'(c1), exp_cnt(1));
    check_eq("n1_clk_out", 32'(o1), exp_out(1));
    check_eq("n2_count", 32'(c2), exp_cnt(2));
    check_eq("n2_clk_out", 32'(o2), exp_out(2));
    check_eq("n3_count", 32'(c3), exp_cnt(3));
    check_eq("n3_clk_out", 32'(o3), exp_out(3));
    check_eq("n4_count", 32'(c4), exp_cnt(4));
    check_eq("n4_clk_out", 32'(o4), exp_out(4));
    check_eq("n8_count", 32'(c8), exp_cnt(8));
    check_eq("n8_clk_out", 32'(o8), exp_out(8));
`ifdef CLK_DIVIDER_TICK_EN
    check_eq("n1_tick", 32'(t1), exp_tick(1));
    check_eq("n2_tick", 32'(t2), exp_tick(2));
    check_eq("n3_tick", 32'(t3), exp_tick(3));
    check_eq("n4_tick", 32'(t4), exp_tick(4));
    check_eq("n8_tick", 32'(t8), exp_tick(8));
`endif
  endtask

  // One clk_in period: update the model at the rising edge, check at the falling edge, then drive.
  task automatic cycle(input logic en_next);
    @(posedge clk_in);
    if (rst_n) begin
      last_en = (en === 1'b1);
      if (en === 1'b1) n_en++;
    end else begin
      last_en = 1'b0;
      n_en    = 0;
    end
    @(negedge clk_in);
    check_all();
    en = en_next;
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    n_en    = 0;
    last_en = 1'b0;
    #1 check_all();
  endtask

  int rise_t[$];
  int guard;
  int k;
  logic prev_o4;

  initial begin
    // Reset held for 3 cycles with en undefined.
    rst_n = 1'b0;
    en    = 1'bx;
    repeat (3) cycle(1'bx);

    // Release before an edge and free-run.
    rst_n = 1'b1;
    en    = 1'b1;
    prev_o4 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1);
      if (o4 && !prev_o4) rise_t.push_back(i);
      prev_o4 = o4;
    end
    check_eq("n4_rise_seen", 32'(rise_t.size() >= 2), 32'd1);
    if (rise_t.size() >= 2) check_eq("n4_period", 32'(rise_t[1] - rise_t[0]), 32'd16);
    check_eq("n4_first_rise_edge", 32'(rise_t.size() > 0 ? rise_t[0] + 1 : 0), 32'd8);

    // Enable hold on the N=3 divider at count 5.
    guard = 0;
    while (exp_cnt(3) != 5 && guard < 20) begin
      cycle(1'b1);
      guard++;
    end
    check_eq("hold_reach5", 32'(c3), 32'd5);
    en = 1'b0;
    repeat (4) cycle(1'b0);
    check_eq("hold_cnt", 32'(c3), 32'd5);
    check_eq("hold_out", 32'(o3), 32'd1);
    en = 1'b1;
    repeat (3) cycle(1'b1);
    check_eq("resume_wrap", 32'(c3), 32'd0);
    check_eq("resume_out", 32'(o3), 32'd0);

    // Mid-run reset on the N=4 divider at count 11, between edges.
    guard = 0;
    while (exp_cnt(4) != 11 && guard < 20) begin
      cycle(1'b1);
      guard++;
    end
    check_eq("pre_rst_out", 32'(o4), 32'd1);
    async_reset();
    check_eq("async_clr_out", 32'(o4), 32'd0);
    check_eq("async_clr_cnt", 32'(c4), 32'd0);
    cycle(1'b1);
    rst_n = 1'b1;
    k = 0;
    while (!o4 && k < 20) begin
      cycle(1'b1);
      k++;
    end
    check_eq("rst_rise_lat", 32'(k), 32'd8);

    // Randomized enable with occasional asynchronous reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
        cycle(1'($urandom_range(0, 3) != 0));
        rst_n = 1'b1;
      end else begin
        cycle(1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
